// File: rtl/pll_lock_reset_seq.sv
// PLL lock qualifier and SoC reset sequencer on the free-running board clock.
// Optional PLL_RESET_SEQ_WATCHDOG_EN adds a WAIT_LOCK watchdog driving pll_rst.
module pll_lock_reset_seq #(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 64,
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    parameter int WATCHDOG_CYCLES    = 250000,
    parameter int PLL_RST_CYCLES     = 16,
`endif
    parameter int LOSS_CNT_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      pll_locked,
    input  logic                      clear_sticky,
    output logic                      sys_reset,
    output logic                      ready,
    output logic                      lock_lost,
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    output logic [LOSS_CNT_WIDTH-1:0] loss_count,
    output logic                      pll_rst
`else
    output logic [LOSS_CNT_WIDTH-1:0] loss_count
`endif
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STABLE    = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RESET_HOLD_CYCLES - 1);

    logic [SYNC_STAGES-1:0]    sync_q, sync_d;
    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sys_reset_q, sys_reset_d;
    logic                      ready_q, ready_d;
    logic                      lock_lost_q, lock_lost_d;
    logic [LOSS_CNT_WIDTH-1:0] loss_count_q, loss_count_d;
    logic                      lock_s;
    logic                      run_lost;

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    localparam int WD_LAST = WATCHDOG_CYCLES + PLL_RST_CYCLES - 1;
    localparam int WD_W    = $clog2(WD_LAST + 1);
    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            pll_rst_q, pll_rst_d;
`endif

    assign sync_d   = {sync_q[SYNC_STAGES-2:0], pll_locked};
    assign lock_s   = sync_q[SYNC_STAGES-1];
    assign run_lost = (state_q == RUN) && !lock_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_count_q <= '0;
        end else begin
            sync_q       <= sync_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            lock_lost_q  <= lock_lost_d;
            loss_count_q <= loss_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = STABLE;
            end
            STABLE: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == STABLE_LAST) state_d = HOLD;
                else cnt_d = cnt_q + 1'b1;
            end
            HOLD: begin
                if (!lock_s) state_d = WAIT_LOCK;
                else if (cnt_q == HOLD_LAST) state_d = RUN;
                else cnt_d = cnt_q + 1'b1;
            end
            RUN: begin
                if (!lock_s) state_d = WAIT_LOCK;
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // A new loss outranks a simultaneous clear so no event is ever missed.
    always_comb begin
        sys_reset_d  = (state_d != RUN);
        ready_d      = (state_d == RUN);
        lock_lost_d  = lock_lost_q;
        loss_count_d = loss_count_q;
        if (clear_sticky) lock_lost_d = 1'b0;
        if (run_lost) begin
            lock_lost_d = 1'b1;
            if (loss_count_q != '1) loss_count_d = loss_count_q + 1'b1;
        end
    end

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            wd_cnt_q  <= '0;
            pll_rst_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            pll_rst_q <= pll_rst_d;
        end
    end

    always_comb begin
        wd_cnt_d  = '0;
        pll_rst_d = 1'b0;
        if (state_q == WAIT_LOCK && state_d == WAIT_LOCK) begin
            if (wd_cnt_q != WD_W'(WD_LAST)) wd_cnt_d = wd_cnt_q + 1'b1;
            pll_rst_d = (wd_cnt_q >= WD_W'(WATCHDOG_CYCLES - 1)) &&
                        (wd_cnt_q != WD_W'(WD_LAST));
        end
    end

    assign pll_rst = pll_rst_q;
`endif

    assign sys_reset  = sys_reset_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_count_q;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq (small qualification windows).
// Define PLL_RESET_SEQ_WATCHDOG_EN to also exercise the watchdog.
module tb_pll_lock_reset_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       clear_sticky = 1'b0;
    logic       sys_reset;
    logic       ready;
    logic       lock_lost;
    logic [7:0] loss_count;
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
    logic       pll_rst;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pll_lock_reset_seq #(
        .SYNC_STAGES       (2),
        .LOCK_STABLE_CYCLES(8),
        .RESET_HOLD_CYCLES (4),
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        .WATCHDOG_CYCLES   (32),
        .PLL_RST_CYCLES    (16),
`endif
        .LOSS_CNT_WIDTH    (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_locked  (pll_locked),
        .clear_sticky(clear_sticky),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .lock_lost   (lock_lost),
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        .loss_count  (loss_count),
        .pll_rst     (pll_rst)
`else
        .loss_count  (loss_count)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        pll_locked   = 1'b0;
        clear_sticky = 1'b0;
        step(3);
        check("rst_sys_reset", 32'(sys_reset), 1);
        check("rst_ready", 32'(ready), 0);
        check("rst_lock_lost", 32'(lock_lost), 0);
        check("rst_loss_count", 32'(loss_count), 0);
`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        check("rst_pll_rst", 32'(pll_rst), 0);
`endif
        reset = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int k;
        k = 0;
        while (!ready && k < 40) begin
            step(1);
            k++;
        end
        check(tag, 32'(ready), 1);
    endtask

    // One-cycle low pulse on pll_locked; FSM leaves RUN on the third edge.
    task automatic drop_once(input logic with_clear);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        clear_sticky = with_clear;
        step(1);
        clear_sticky = 1'b0;
    endtask

    initial begin
        // 1: no lock keeps reset asserted
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_outs", 32'({sys_reset, ready}), 32'h2);
        end
        check("idle_loss", 32'(loss_count), 0);

        // 2: release 15 edges after pll_locked rises
        pll_locked = 1'b1;
        step(14);
        check("rel_early_sys", 32'(sys_reset), 1);
        check("rel_early_rdy", 32'(ready), 0);
        step(1);
        check("rel_sys", 32'(sys_reset), 0);
        check("rel_rdy", 32'(ready), 1);

        // 3: one-cycle lock drop in RUN
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        check("drop_still_run", 32'({sys_reset, ready}), 32'h1);
        step(1);
        check("drop_sys", 32'(sys_reset), 1);
        check("drop_rdy", 32'(ready), 0);
        check("drop_lost", 32'(lock_lost), 1);
        check("drop_cnt", 32'(loss_count), 1);
        step(12);
        check("requal_early", 32'(sys_reset), 1);
        step(1);
        check("requal_sys", 32'(sys_reset), 0);
        check("requal_rdy", 32'(ready), 1);
        check("requal_lost", 32'(lock_lost), 1);

        // reset mid-operation clears everything
        do_reset();

        // 4: 5-cycle lock glitches never release reset
        for (int p = 0; p < 5; p++) begin
            pll_locked = 1'b1;
            for (int i = 0; i < 5; i++) begin
                step(1);
                check("glitch_sys", 32'(sys_reset), 1);
            end
            pll_locked = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step(1);
                check("glitch_sys", 32'(sys_reset), 1);
            end
        end
        check("glitch_loss", 32'(loss_count), 0);

        // 5: saturation and sticky priority
        do_reset();
        pll_locked = 1'b1;
        for (int n = 0; n < 300; n++) begin
            wait_ready("sat_ready");
            drop_once(1'b0);
        end
        check("sat_count", 32'(loss_count), 255);
        check("sat_lost", 32'(lock_lost), 1);
        wait_ready("clr_ready");
        clear_sticky = 1'b1;
        step(1);
        clear_sticky = 1'b0;
        check("clr_alone", 32'(lock_lost), 0);
        wait_ready("both_ready");
        drop_once(1'b1);
        check("set_wins", 32'(lock_lost), 1);
        check("sat_hold", 32'(loss_count), 255);

`ifdef PLL_RESET_SEQ_WATCHDOG_EN
        // 6: watchdog pulses and lock mid-pulse
        do_reset();
        step(31);
        check("wd_pre", 32'(pll_rst), 0);
        step(1);
        check("wd_rise", 32'(pll_rst), 1);
        step(15);
        check("wd_last", 32'(pll_rst), 1);
        step(1);
        check("wd_fall", 32'(pll_rst), 0);
        step(31);
        check("wd_gap", 32'(pll_rst), 0);
        step(1);
        check("wd_rise2", 32'(pll_rst), 1);
        step(4);
        pll_locked = 1'b1;
        step(2);
        check("wd_mid", 32'(pll_rst), 1);
        step(1);
        check("wd_lock_clr", 32'(pll_rst), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
